bp_be_late_wb_arbiter: RTL



---
 rtl/bp_be_pkg.sv | 26 ++
 rtl/bp_be_late_wb_src_fifo.sv | 60 ++++++
 rtl/bp_be_late_wb_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared BE types for the late writeback arbiter: FSM state enum, writeback packet, width helper.
// Consumed by bp_be_late_wb_arbiter (optional feature macro: BP_BE_LATE_WB_STARVE_EN).
package bp_be_pkg;

  typedef enum logic {
    e_idle,
    e_locked
  } bp_be_late_wb_arb_state_e;

  typedef struct packed {
    logic        ird_w_v;
    logic        frd_w_v;
    logic        fflags_w_v;
    logic [4:0]  rd_addr;
    logic [64:0] rd_data;
    logic [4:0]  fflags;
  } bp_be_wb_pkt_s;

  localparam int unsigned bp_be_wb_pkt_width_gp = $bits(bp_be_wb_pkt_s);

  // Index width that never collapses to zero bits for single-entry structures.
  function automatic int unsigned bp_be_clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_be_late_wb_src_fifo.sv
// Per-source late writeback buffer: els_p-deep 1r1w FIFO holding {force, pkt}.
// Enqueue is gated by full here; the caller only dequeues a non-empty FIFO.
module bp_be_late_wb_src_fifo
  import bp_be_pkg::*;
#(
  parameter int unsigned els_p   = 2,
  parameter int unsigned width_p = 79
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               yumi_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  localparam int unsigned ptr_w_lp = bp_be_clog2_min1(els_p);
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wptr;
  logic [ptr_w_lp-1:0] r_rptr;
  logic [cnt_w_lp-1:0] r_cnt;
  logic                w_enq;
  logic                w_deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_cnt == cnt_w_lp'(els_p));
  assign empty_o = (r_cnt == '0);
  assign w_enq   = v_i & ~full_o;
  assign w_deq   = yumi_i & ~empty_o;
  assign data_o  = r_mem[r_rptr];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= ptr_inc(r_wptr);
      if (w_deq) r_rptr <= ptr_inc(r_rptr);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// N-source late writeback arbiter: per-source FIFOs, force priority, round-robin, grant lock.
// Optional starvation escalation enabled by macro BP_BE_LATE_WB_STARVE_EN.
//
// state    | meaning
// e_idle   | arbitrate over FIFO heads each cycle; winner shown on the late wb port
// e_locked | winner was not consumed; hold grant_r until yumi, no preemption
module bp_be_late_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int unsigned num_src_p      = 3,
  parameter int unsigned els_p          = 2,
  parameter int unsigned wb_pkt_width_p = bp_be_wb_pkt_width_gp,
  parameter int unsigned starve_limit_p = 15,
  localparam int unsigned src_w_lp      = bp_be_clog2_min1(num_src_p)
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_src_p*wb_pkt_width_p-1:0] src_pkt_i,
  input  logic [num_src_p-1:0]                src_v_i,
  input  logic [num_src_p-1:0]                src_force_i,
  output logic [num_src_p-1:0]                src_ready_and_o,
  output logic [wb_pkt_width_p-1:0]           late_wb_pkt_o,
  output logic                                late_wb_v_o,
  output logic                                late_wb_force_o,
  output logic [src_w_lp-1:0]                 late_wb_src_o,
  input  logic                                late_wb_yumi_i,
  output logic                                late_wb_pending_o
);

  logic [num_src_p-1:0]      w_full;
  logic [num_src_p-1:0]      w_empty;
  logic [num_src_p-1:0]      w_head_force;
  logic [num_src_p-1:0]      w_eff_force;
  logic [num_src_p-1:0]      w_deq;
  logic [wb_pkt_width_p:0]   w_head_data [num_src_p];
  logic [wb_pkt_width_p-1:0] w_head_pkt  [num_src_p];

  for (genvar i = 0; i < num_src_p; i++) begin : g_src
    bp_be_late_wb_src_fifo #(
      .els_p   (els_p),
      .width_p (wb_pkt_width_p + 1)
    ) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .v_i       (src_v_i[i]),
      .data_i    ({src_force_i[i], src_pkt_i[i*wb_pkt_width_p +: wb_pkt_width_p]}),
      .yumi_i    (w_deq[i]),
      .full_o    (w_full[i]),
      .empty_o   (w_empty[i]),
      .data_o    (w_head_data[i])
    );
    assign w_head_force[i] = w_head_data[i][wb_pkt_width_p];
    assign w_head_pkt[i]   = w_head_data[i][wb_pkt_width_p-1:0];
  end

`ifdef BP_BE_LATE_WB_STARVE_EN
  localparam int unsigned starve_w_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_w_lp-1:0] starve_max_lp = starve_w_lp'(starve_limit_p);

  logic [starve_w_lp-1:0] r_starve [num_src_p];

  // Age of each head in cycles without being consumed, saturating at the limit.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_src_p; i++) begin
      if (!reset_n_i || w_empty[i] || w_deq[i]) r_starve[i] <= '0;
      else if (r_starve[i] != starve_max_lp)    r_starve[i] <= r_starve[i] + 1'b1;
    end
  end

  for (genvar i = 0; i < num_src_p; i++) begin : g_eff_force
    assign w_eff_force[i] = w_head_force[i] | (r_starve[i] == starve_max_lp);
  end
`else
  assign w_eff_force = w_head_force;
`endif

  bp_be_late_wb_arb_state_e r_state;
  bp_be_late_wb_arb_state_e w_state_nxt;
  logic [src_w_lp-1:0]      r_grant;
  logic [src_w_lp-1:0]      w_grant_nxt;
  logic [src_w_lp-1:0]      r_rr_ptr;
  logic [src_w_lp-1:0]      w_rr_ptr_nxt;
  logic                     r_force;
  logic                     w_force_nxt;
  logic [src_w_lp-1:0]      w_win;
  logic [src_w_lp-1:0]      w_force_win;
  logic [src_w_lp-1:0]      w_rr_win;
  logic                     w_force_hit;
  logic                     w_any_v;
  logic [src_w_lp-1:0]      w_sel;
  logic                     w_sel_force;
  logic                     w_v;

  function automatic logic [src_w_lp-1:0] rr_inc(input logic [src_w_lp-1:0] p);
    return (p == src_w_lp'(num_src_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_any_v = ~&w_empty;

  // Descending scans so the last hit is the lowest index / nearest to rr_ptr.
  always_comb begin
    w_force_hit = 1'b0;
    w_force_win = '0;
    w_rr_win    = '0;
    for (int i = num_src_p - 1; i >= 0; i--) begin
      if (!w_empty[i] && w_eff_force[i]) begin
        w_force_hit = 1'b1;
        w_force_win = src_w_lp'(i);
      end
    end
    for (int k = num_src_p - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_rr_ptr) + k;
      if (idx >= int'(num_src_p)) idx = idx - int'(num_src_p);
      if (!w_empty[idx]) w_rr_win = src_w_lp'(idx);
    end
    w_win = w_force_hit ? w_force_win : w_rr_win;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_force_nxt  = r_force;
    w_rr_ptr_nxt = r_rr_ptr;
    w_sel        = r_grant;
    w_sel_force  = r_force;
    w_v          = 1'b0;
    w_deq        = '0;
    unique case (r_state)
      e_idle: begin
        w_sel       = w_win;
        w_sel_force = w_eff_force[w_win];
        w_v         = w_any_v;
        if (w_any_v) begin
          if (late_wb_yumi_i) begin
            w_deq[w_win] = 1'b1;
            w_rr_ptr_nxt = rr_inc(w_win);
          end else begin
            w_state_nxt = e_locked;
            w_grant_nxt = w_win;
            w_force_nxt = w_eff_force[w_win];
          end
        end
      end
      e_locked: begin
        // Force is held from lock time so a head aging past the limit cannot glitch it.
        w_v = 1'b1;
        if (late_wb_yumi_i) begin
          w_deq[r_grant] = 1'b1;
          w_rr_ptr_nxt   = rr_inc(r_grant);
          w_state_nxt    = e_idle;
        end
      end
      default: begin
        w_state_nxt = e_idle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= e_idle;
      r_grant  <= '0;
      r_force  <= 1'b0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_force  <= w_force_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  assign late_wb_v_o       = reset_n_i & w_v;
  assign late_wb_force_o   = late_wb_v_o & w_sel_force;
  assign late_wb_src_o     = late_wb_v_o ? w_sel : '0;
  assign late_wb_pkt_o     = late_wb_v_o ? w_head_pkt[w_sel] : '0;
  assign late_wb_pending_o = reset_n_i & w_any_v;
  assign src_ready_and_o   = {num_src_p{reset_n_i}} & ~w_full;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(late_wb_yumi_i && !late_wb_v_o))
        else $error("late_wb_yumi_i asserted while late_wb_v_o is low");
    end
  end
`endif

endmodule
